// File: rtl/audio_fifo_1r1w.sv
// audio_fifo_1r1w: single-clock FIFO for multi-channel audio frames with
// ready/valid on both sides, first-word-fall-through output and registered
// occupancy status. Channel 0 sits in the data LSBs.
// Optional jitter-buffer holdoff: define AUDIO_FIFO_HOLDOFF_EN to hold valid_o
// low until PREFILL_P frames are buffered, and again after an underrun.
module audio_fifo_1r1w #(
  parameter int unsigned WIDTH_P    = 24,
  parameter int unsigned CHANNELS_P = 2,
  parameter int unsigned DEPTH_P    = 16,
  parameter int unsigned AFULL_P    = 12,
  parameter int unsigned PREFILL_P  = 8
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [CHANNELS_P*WIDTH_P-1:0]     data_i,
  input  logic                              valid_i,
  output logic                              ready_o,
  output logic [CHANNELS_P*WIDTH_P-1:0]     data_o,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [$clog2(DEPTH_P+1)-1:0]      count_o,
  output logic                              full_o,
  output logic                              empty_o,
  output logic                              almost_full_o
);

  localparam int unsigned DW = CHANNELS_P * WIDTH_P;
  localparam int unsigned AW = $clog2(DEPTH_P);
  localparam int unsigned CW = $clog2(DEPTH_P + 1);

  // Elaboration-time parameter sanity checks
  if (DEPTH_P < 2 || (DEPTH_P & (DEPTH_P - 1)) != 0) begin : g_bad_depth
    $error("audio_fifo_1r1w: DEPTH_P must be a power of 2 and >= 2");
  end
  if (AFULL_P < 1 || AFULL_P > DEPTH_P) begin : g_bad_afull
    $error("audio_fifo_1r1w: AFULL_P out of range 1..DEPTH_P");
  end
  if (PREFILL_P < 1 || PREFILL_P > DEPTH_P) begin : g_bad_prefill
    $error("audio_fifo_1r1w: PREFILL_P out of range 1..DEPTH_P");
  end

  logic [DW-1:0] mem [DEPTH_P];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          wr_en;
  logic          rd_en;

  // Handshakes and status, all derived from the registered count
  always_comb begin
    full_o        = (count_q == CW'(DEPTH_P));
    empty_o       = (count_q == '0);
    almost_full_o = (count_q >= CW'(AFULL_P));
    count_o       = count_q;
    ready_o       = ~full_o;
    wr_en         = valid_i & ready_o;
    rd_en         = valid_o & ready_i;
    data_o        = mem[rd_ptr_q];
  end

  // Occupancy update: simultaneous read and write leaves count unchanged
  always_comb begin
    count_d = count_q;
    if (wr_en && !rd_en)
      count_d = count_q + CW'(1);
    else if (rd_en && !wr_en)
      count_d = count_q - CW'(1);
  end

  // Frame storage; contents are intentionally not cleared by reset
  always_ff @(posedge clk_i) begin
    if (wr_en)
      mem[wr_ptr_q] <= data_i;
  end

  // Pointers and count; pointers wrap naturally at DEPTH_P
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en)
        wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en)
        rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

`ifdef AUDIO_FIFO_HOLDOFF_EN
  typedef enum logic {FILL, RUN} hold_state_e;
  hold_state_e state_q;
  hold_state_e state_d;

  // Holdoff state register
  always_ff @(posedge clk_i) begin
    if (reset_i)
      state_q <= FILL;
    else
      state_q <= state_d;
  end

  // Holdoff next state: release at prefill level, re-arm on underrun
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: if (count_q >= CW'(PREFILL_P)) state_d = RUN;
      RUN:  if (rd_en && !wr_en && count_q == CW'(1)) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Holdoff output: head frame is presented only while streaming
  always_comb begin
    valid_o = (state_q == RUN) & ~empty_o;
  end
`else
  // Head frame is valid whenever the FIFO holds anything
  always_comb begin
    valid_o = ~empty_o;
  end
`endif

endmodule

// File: tb/tb_audio_fifo_1r1w.sv
// Randomised self-checking bench for audio_fifo_1r1w against a queue model.
module tb_audio_fifo_1r1w;

  localparam int unsigned W   = 24;
  localparam int unsigned C   = 2;
  localparam int unsigned D   = 16;
  localparam int unsigned AF  = 12;
  localparam int unsigned PF  = 8;
  localparam int unsigned DW  = W * C;
  localparam int unsigned CW  = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          reset_i;
  logic [DW-1:0] data_i;
  logic          valid_i;
  logic          ready_o;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i;
  logic [CW-1:0] count_o;
  logic          full_o;
  logic          empty_o;
  logic          almost_full_o;

  always #5 clk = ~clk;

  audio_fifo_1r1w #(
    .WIDTH_P(W), .CHANNELS_P(C), .DEPTH_P(D), .AFULL_P(AF), .PREFILL_P(PF)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o),
    .almost_full_o(almost_full_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: contents as a queue, plus holdoff streaming flag
  logic [DW-1:0] q [$];
  bit            run_m = 1'b0;
  int            reads_m = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_valid();
`ifdef AUDIO_FIFO_HOLDOFF_EN
    return run_m && (q.size() > 0);
`else
    return q.size() > 0;
`endif
  endfunction

  task automatic check_outputs(input string tag);
    int sz;
    sz = q.size();
    check_val({tag, "_count"}, 64'(count_o), 64'(sz));
    check_val({tag, "_empty"}, 64'(empty_o), 64'(sz == 0));
    check_val({tag, "_full"},  64'(full_o),  64'(sz == D));
    check_val({tag, "_afull"}, 64'(almost_full_o), 64'(sz >= AF));
    check_val({tag, "_ready"}, 64'(ready_o), 64'(sz < D));
    check_val({tag, "_valid"}, 64'(valid_o), 64'(model_valid()));
    if (model_valid())
      check_val({tag, "_data"}, 64'(data_o), 64'(q[0]));
  endtask

  function automatic logic [DW-1:0] rand_frame();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[DW-1:0];
  endfunction

  // One clock: drive at negedge, update model at posedge, check at next negedge
  task automatic step(input string tag, input bit rst, input bit v, input bit r,
                      input logic [DW-1:0] d);
    bit wr, rd, run_n;
    reset_i = rst;
    valid_i = v;
    ready_i = r;
    data_i  = d;
    wr = v && (q.size() < D);
    rd = model_valid() && r;
    if (!run_m) run_n = (q.size() >= PF);
    else        run_n = !(rd && !wr && q.size() == 1);
    @(posedge clk);
    if (rst) begin
      q.delete();
      run_m = 1'b0;
    end else begin
      if (rd) begin
        void'(q.pop_front());
        reads_m++;
      end
      if (wr) q.push_back(d);
      run_m = run_n;
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    int guard;
    int reads_base;
    int cyc;
    reset_i = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    data_i  = '0;
    @(negedge clk);

    // Reset
    step("reset", 1'b1, 1'b0, 1'b0, '0);
    step("reset", 1'b1, 1'b0, 1'b0, '0);
    step("post_reset", 1'b0, 1'b0, 1'b0, '0);
    check_val("reset_ready", 64'(ready_o), 64'd1);
    check_val("reset_count", 64'(count_o), 64'd0);

    // Three writes with the consumer stalled
    for (int unsigned i = 0; i < 3; i++)
      step("wr3", 1'b0, 1'b1, 1'b0, rand_frame());
    check_val("wr3_count", 64'(count_o), 64'd3);

    // Fill to DEPTH, then one extra write that must be dropped
    for (int unsigned i = 0; i < 14; i++)
      step("fill", 1'b0, 1'b1, 1'b0, rand_frame());
    check_val("drop_count", 64'(count_o), 64'(D));
    check_val("drop_full", 64'(full_o), 64'd1);

    // Full FIFO streaming across pointer wrap
    for (int unsigned i = 0; i < 40; i++) begin
      step("wrap", 1'b0, 1'b1, 1'b1, rand_frame());
      check_val("wrap_range", 64'(count_o >= CW'(15) && count_o <= CW'(16)), 64'd1);
    end

    // Drain to 9 entries, then reset mid-operation
    guard = 0;
    while (q.size() > 9 && guard < 40) begin
      step("drain9", 1'b0, 1'b0, 1'b1, '0);
      guard++;
    end
    check_val("pre_reset_count", 64'(count_o), 64'd9);
    step("mid_reset", 1'b1, 1'b0, 1'b0, '0);
    check_val("mid_reset_count", 64'(count_o), 64'd0);
    for (int unsigned i = 0; i < 10; i++)
      step("restart", 1'b0, 1'b1, 1'b0, rand_frame());
    for (int unsigned i = 0; i < 12; i++)
      step("restart_rd", 1'b0, 1'b0, 1'b1, '0);

    // Random traffic with phase-varying bias to hit both full and empty
    reads_base = reads_m;
    cyc = 0;
    while (reads_m - reads_base < 10000 && cyc < 60000) begin
      int unsigned ph;
      bit v, r;
      ph = (cyc / 400) % 3;
      v = (ph == 0) ? ($urandom_range(0, 3) != 0) :
          (ph == 1) ? ($urandom_range(0, 3) == 0) : $urandom_range(0, 1) != 0;
      r = (ph == 0) ? ($urandom_range(0, 3) == 0) :
          (ph == 1) ? ($urandom_range(0, 3) != 0) : $urandom_range(0, 1) != 0;
      step("rand", 1'b0, v, r, rand_frame());
      cyc++;
    end
    if (reads_m - reads_base < 10000)
      check_val("rand_budget", 64'd0, 64'd1);

`ifdef AUDIO_FIFO_HOLDOFF_EN
    // Prefill holdoff: no output until PREFILL frames buffered
    step("ho_reset", 1'b1, 1'b0, 1'b0, '0);
    for (int unsigned i = 0; i < PF - 1; i++)
      step("ho_fill", 1'b0, 1'b1, 1'b1, rand_frame());
    check_val("ho_hold", 64'(valid_o), 64'd0);
    step("ho_8th", 1'b0, 1'b1, 1'b0, rand_frame());
    step("ho_rel", 1'b0, 1'b0, 1'b0, '0);
    check_val("ho_release", 64'(valid_o), 64'd1);
    guard = 0;
    while (q.size() > 0 && guard < 40) begin
      step("ho_drain", 1'b0, 1'b0, 1'b1, '0);
      guard++;
    end
    check_val("ho_empty", 64'(empty_o), 64'd1);
    for (int unsigned i = 0; i < PF - 1; i++)
      step("ho_refill", 1'b0, 1'b1, 1'b1, rand_frame());
    check_val("ho_rehold", 64'(valid_o), 64'd0);
    step("ho_8th_again", 1'b0, 1'b1, 1'b0, rand_frame());
    step("ho_rel_again", 1'b0, 1'b0, 1'b0, '0);
    check_val("ho_rerelease", 64'(valid_o), 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
